// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Holds the arbiter FSM state type and the pointer-width helper.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 16;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational rotate-priority picker: searches from i_ptr+1 upward, wrapping,
// and grants the first active request.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx
);

    logic             w_found;
    logic [PTR_W-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            w_j = PTR_W'((int'(i_ptr) + k) % int'(NUM_REQ));
            if (i_en && !w_found && i_req[w_j]) begin
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers, with
// full throttling and wr_ack/overflow checking. Define FIFO_ARB_STATS_EN for counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arb_en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic [1:0]                    arb_state,
    output logic                          drop_err,
`ifdef FIFO_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]         grant_cnt,
    output logic [15:0]                   stall_cnt,
`endif
    input  logic                          clr_err
);

    localparam int unsigned PTR_W = ptr_w(NUM_REQ);

    arb_state_t              r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic                    r_wr_en;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_pend;
    logic                    r_drop;

    logic                    w_can_write;
    logic                    w_any;
    logic                    w_xfer;
    logic                    w_lost;
    logic [NUM_REQ-1:0]      w_grant;
    logic [PTR_W-1:0]        w_idx;
    logic [DATA_WIDTH-1:0]   w_req_data [NUM_REQ];

    // A write already presented while almost_full will fill the FIFO, so hold off.
    assign w_can_write = arb_en && !fifo_full && !(fifo_almost_full && r_wr_en);
    assign w_any       = |req_valid;
    assign w_xfer      = |(req_valid & w_grant);
    assign w_lost      = r_pend && (!fifo_wr_ack || fifo_overflow);

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
        assign w_req_data[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Reset also masks the combinational ready so nothing is accepted while held.
    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_can_write && rst_n),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) r_state <= w_can_write ? ACTIVE : STALL;
                end
                ACTIVE: begin
                    if (!w_any)            r_state <= IDLE;
                    else if (!w_can_write) r_state <= STALL;
                end
                STALL: begin
                    if (!w_any)           r_state <= IDLE;
                    else if (w_can_write) r_state <= ACTIVE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= PTR_W'(NUM_REQ - 1);
            r_wr_en <= 1'b0;
            r_data  <= '0;
            r_pend  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_wr_en <= w_xfer;
            r_pend  <= r_wr_en;
            if (w_xfer) begin
                r_data <= w_req_data[w_idx];
                r_ptr  <= w_idx;
            end
            if (w_lost)       r_drop <= 1'b1;
            else if (clr_err) r_drop <= 1'b0;
        end
    end

    assign req_ready    = w_grant;
    assign fifo_wr_en   = r_wr_en;
    assign fifo_data_in = r_data;
    assign arb_state    = r_state;
    assign drop_err     = r_drop;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_cnt
        logic [15:0] r_grant_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_grant_cnt <= '0;
            end else if (clr_err) begin
                r_grant_cnt <= '0;
            end else if (req_valid[g] && w_grant[g] && (r_grant_cnt != 16'hFFFF)) begin
                r_grant_cnt <= r_grant_cnt + 16'd1;
            end
        end
        assign grant_cnt[g*16 +: 16] = r_grant_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (clr_err) begin
            r_stall_cnt <= '0;
        end else if ((r_state == STALL) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a FIFO environment plus a cycle-level
// reference model of grants, writes, FSM state and the lost-write flag.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam logic [N-1:0] ONE = 1;

    logic            clk;
    logic            rst_n;
    logic            arb_en;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data_in;
    logic            fifo_full;
    logic            fifo_almost_full;
    logic            fifo_wr_ack;
    logic            fifo_overflow;
    logic [1:0]      arb_state;
    logic            drop_err;
    logic            clr_err;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
    logic [15:0]     stall_cnt;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .arb_en           (arb_en),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_data_in     (fifo_data_in),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_wr_ack      (fifo_wr_ack),
        .fifo_overflow    (fifo_overflow),
        .arb_state        (arb_state),
        .drop_err         (drop_err),
`ifdef FIFO_ARB_STATS_EN
        .grant_cnt        (grant_cnt),
        .stall_cnt        (stall_cnt),
`endif
        .clr_err          (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int n_ovf    = 0;

    // FIFO environment
    int   env_count = 0;
    int   env_depth = 1000;
    logic rd        = 1'b0;
    logic withhold  = 1'b0;

    // Reference model
    int            m_last;
    logic          m_wr_en;
    logic          m_pend;
    logic          m_err;
    logic [DW-1:0] m_data;
    logic [1:0]    m_state;

    // Values sampled mid-cycle by tick()
    logic [N-1:0]  s_ready = '0;
    logic          s_wr_en = 1'b0;
    logic [DW-1:0] s_data;
    logic [1:0]    s_state;
    logic          s_err;

    task automatic env_flags();
        fifo_full        = (env_count >= env_depth);
        fifo_almost_full = (env_count >= env_depth - 1);
    endtask

    task automatic model_reset();
        m_last  = N - 1;
        m_wr_en = 1'b0;
        m_pend  = 1'b0;
        m_err   = 1'b0;
        m_data  = '0;
        m_state = 2'd0;
    endtask

    // One clock: check everything against the model mid-cycle, then advance
    // model and FIFO environment just after the edge.
    task automatic tick();
        logic         can;
        int           g;
        logic [N-1:0] exp_ready;
        logic [N-1:0] rot;
        logic [1:0]   n_state;
        logic         n_err;
        @(negedge clk);
        can = arb_en && !fifo_full && !(fifo_almost_full && m_wr_en);
        g = -1;
        for (int k = 1; k <= N; k++) begin
            rot = req_valid >> ((m_last + k) % N);
            if (g < 0 && can && rot[0]) g = (m_last + k) % N;
        end
        exp_ready = (g >= 0) ? (ONE << g) : '0;
        s_ready = req_ready;
        s_wr_en = fifo_wr_en;
        s_data  = fifo_data_in;
        s_state = arb_state;
        s_err   = drop_err;
        n_checks++;
        if (req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL ready @%0t: got %b want %b", $time, req_ready, exp_ready);
        end
        n_checks++;
        if (fifo_wr_en !== m_wr_en) begin
            n_fail++;
            $display("FAIL wr_en @%0t: got %b want %b", $time, fifo_wr_en, m_wr_en);
        end
        n_checks++;
        if (fifo_data_in !== m_data) begin
            n_fail++;
            $display("FAIL data @%0t: got %h want %h", $time, fifo_data_in, m_data);
        end
        n_checks++;
        if (arb_state !== m_state) begin
            n_fail++;
            $display("FAIL state @%0t: got %0d want %0d", $time, arb_state, m_state);
        end
        n_checks++;
        if (drop_err !== m_err) begin
            n_fail++;
            $display("FAIL drop_err @%0t: got %b want %b", $time, drop_err, m_err);
        end
        @(posedge clk);
        #1;
        n_state = (req_valid == '0) ? 2'd0 : (can ? 2'd1 : 2'd2);
        n_err   = (m_pend && (!fifo_wr_ack || fifo_overflow)) ? 1'b1 :
                  (clr_err ? 1'b0 : m_err);
        m_pend  = m_wr_en;
        m_wr_en = (g >= 0);
        if (g >= 0) begin
            m_data = req_data[g*DW +: DW];
            m_last = g;
        end
        m_state = n_state;
        m_err   = n_err;
        if (fifo_overflow) n_ovf++;
        if (s_wr_en) n_writes++;
        fifo_overflow = s_wr_en && fifo_full;
        fifo_wr_ack   = s_wr_en && !fifo_full && !withhold;
        if (s_wr_en && !fifo_full) env_count++;
        if (rd && env_count > 0) env_count--;
        env_flags();
    endtask

    task automatic refresh_granted();
        for (int i = 0; i < N; i++)
            if (s_ready[i]) req_data[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic drain(input int cycles);
        req_valid = '0;
        for (int c = 0; c < cycles; c++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arb_en = 1'b1; req_valid = '1; req_data = '0; clr_err = 1'b0;
        fifo_wr_ack = 1'b0; fifo_overflow = 1'b0; env_flags();
        #12;
        n_checks++;
        if (req_ready !== '0 || fifo_wr_en !== 1'b0 || fifo_data_in !== '0 ||
            drop_err !== 1'b0 || arb_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: got ready=%b wr=%b data=%h err=%b st=%0d want all 0",
                     req_ready, fifo_wr_en, fifo_data_in, drop_err, arb_state);
        end
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        req_data[DW-1:0] = 16'h00A5;
        tick();
        n_checks++;
        if (s_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_ready: got %b want 0001", s_ready);
        end
        req_valid = '0;
        tick();
        n_checks++;
        if (s_wr_en !== 1'b1 || s_data !== 16'h00A5) begin
            n_fail++;
            $display("FAIL single_write: got wr=%b data=%h want 1/00a5", s_wr_en, s_data);
        end
        tick(); tick();
        n_checks++;
        if (s_err !== 1'b0) begin
            n_fail++; $display("FAIL single_ack: got drop_err=%b want 0", s_err);
        end
    endtask

    task automatic test_round_robin();
        int gcnt [N];
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
        req_valid = '1;
        for (int c = 0; c < 40; c++) begin
            tick();
            for (int i = 0; i < N; i++) if (s_ready[i]) gcnt[i]++;
            refresh_granted();
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (gcnt[i] != 10) begin
                n_fail++; $display("FAIL rr_share[%0d]: got %0d grants want 10", i, gcnt[i]);
            end
        end
        drain(3);
    endtask

    task automatic test_fill();
        env_count = 0; env_depth = 8; env_flags();
        n_writes = 0; n_ovf = 0;
        req_valid = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            tick();
            refresh_granted();
        end
        n_checks++;
        if (n_writes != 8 || n_ovf != 0 || s_state !== 2'd2) begin
            n_fail++;
            $display("FAIL fill: got writes=%0d ovf=%0d state=%0d want 8/0/2",
                     n_writes, n_ovf, s_state);
        end
    endtask

    task automatic test_free_slot();
        int n_act = 0;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        n_writes = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (s_state == 2'd1) n_act++;
            refresh_granted();
        end
        n_checks++;
        if (n_writes != 1 || n_act != 1 || s_state !== 2'd2) begin
            n_fail++;
            $display("FAIL free_slot: got writes=%0d active=%0d state=%0d want 1/1/2",
                     n_writes, n_act, s_state);
        end
        drain(3);
        env_count = 0; env_depth = 1000; env_flags();
        tick();
    endtask

    task automatic test_lost_ack();
        withhold = 1'b1;
        req_valid = 4'b0001;
        req_data[DW-1:0] = DW'($urandom);
        tick();
        req_valid = '0;
        tick(); tick(); tick();
        n_checks++;
        if (s_err !== 1'b1) begin
            n_fail++; $display("FAIL lost_ack_set: got drop_err=%b want 1", s_err);
        end
        withhold = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (s_err !== 1'b1) begin
            n_fail++; $display("FAIL lost_ack_sticky: got drop_err=%b want 1", s_err);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
        n_checks++;
        if (s_err !== 1'b0) begin
            n_fail++; $display("FAIL lost_ack_clear: got drop_err=%b want 0", s_err);
        end
    endtask

    task automatic test_random();
        env_count = 0; env_depth = 8; env_flags();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && s_ready[i]) begin
                    req_valid[i] = 1'($urandom % 2);
                    req_data[i*DW +: DW] = DW'($urandom);
                end else if (!req_valid[i]) begin
                    req_valid[i] = ($urandom % 3 == 0);
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            arb_en   = ($urandom % 8 != 0);
            rd       = 1'($urandom % 2);
            clr_err  = ($urandom % 10 == 0);
            withhold = ($urandom % 20 == 0);
            tick();
        end
        arb_en = 1'b1; rd = 1'b0; clr_err = 1'b0; withhold = 1'b0;
        drain(3);
    endtask

    task automatic test_reset_mid();
        env_count = 0; env_depth = 1000; env_flags();
        req_valid = '1;
        tick(); tick(); tick();
        refresh_granted();
        n_checks++;
        if (fifo_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: got wr_en=%b want 1", fifo_wr_en);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== '0 || fifo_wr_en !== 1'b0 || fifo_data_in !== '0 ||
            drop_err !== 1'b0 || arb_state !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got ready=%b wr=%b data=%h err=%b st=%0d want all 0",
                     req_ready, fifo_wr_en, fifo_data_in, drop_err, arb_state);
        end
        model_reset();
        fifo_wr_ack = 1'b0; fifo_overflow = 1'b0; env_count = 0; env_flags();
        s_wr_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (s_ready !== 4'b0001) begin
            n_fail++; $display("FAIL mid_first: got ready=%b want 0001", s_ready);
        end
        tick();
        n_checks++;
        if (s_ready !== 4'b0010) begin
            n_fail++; $display("FAIL mid_second: got ready=%b want 0010", s_ready);
        end
        drain(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fill();
        test_free_slot();
        test_lost_ack();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
